// File: rtl/rx_byte_assembler_if.sv
// Byte-stream bus of the receive byte assembler: byte strobe and abort from
// the receiver side, assembled word and frame status back out.
interface rx_byte_assembler_if;
    logic [7:0]   byte_data;
    logic         byte_valid;
    logic         clear;
    logic [127:0] rx_data;
    logic         reg_enable;
    logic [4:0]   byte_count;
    logic         busy;
    logic         frame_error;

    modport master (
        output byte_data, byte_valid, clear,
        input  rx_data, reg_enable, byte_count, busy, frame_error
    );

    modport slave (
        input  byte_data, byte_valid, clear,
        output rx_data, reg_enable, byte_count, busy, frame_error
    );
endinterface

// File: rtl/rx_byte_assembler.sv
// Collects 16 received bytes MSB-first into a 128-bit word for the key register
// stage, aborting partial frames on clear or after an idle timeout.
module rx_byte_assembler #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                rst,
    rx_byte_assembler_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t         state_reg, state_next;
    // Holds the 15 bytes preceding the last one; the 16th byte goes straight into rx_data.
    logic [119:0]   shift_reg, shift_next;
    logic [127:0]   rx_data_reg, rx_data_next;
    logic [4:0]     count_reg, count_next;
    logic [15:0]    timer_reg, timer_next;
    logic           reg_enable_reg, reg_enable_next;
    logic           busy_reg, busy_next;
    logic           frame_error_reg, frame_error_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            shift_reg       <= '0;
            rx_data_reg     <= '0;
            count_reg       <= '0;
            timer_reg       <= '0;
            reg_enable_reg  <= 1'b0;
            busy_reg        <= 1'b0;
            frame_error_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            shift_reg       <= shift_next;
            rx_data_reg     <= rx_data_next;
            count_reg       <= count_next;
            timer_reg       <= timer_next;
            reg_enable_reg  <= reg_enable_next;
            busy_reg        <= busy_next;
            frame_error_reg <= frame_error_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        shift_next       = shift_reg;
        rx_data_next     = rx_data_reg;
        count_next       = count_reg;
        timer_next       = timer_reg;
        reg_enable_next  = 1'b0;
        frame_error_next = 1'b0;

        if (bus.clear) begin
            state_next = IDLE;
            count_next = '0;
            timer_next = '0;
        end else if (bus.byte_valid) begin
            shift_next = {shift_reg[111:0], bus.byte_data};
            timer_next = '0;
            if (state_reg == COLLECT && count_reg == 5'd15) begin
                rx_data_next    = {shift_reg, bus.byte_data};
                reg_enable_next = 1'b1;
                count_next      = '0;
                state_next      = DONE;
            end else if (state_reg == COLLECT) begin
                count_next = count_reg + 5'd1;
            end else begin
                // From IDLE or DONE this byte starts a new frame.
                state_next = COLLECT;
                count_next = 5'd1;
            end
        end else begin
            case (state_reg)
                COLLECT: begin
                    if (timer_reg == TIMEOUT_LAST) begin
                        state_next       = IDLE;
                        count_next       = '0;
                        timer_next       = '0;
                        frame_error_next = 1'b1;
                    end else begin
                        timer_next = timer_reg + 16'd1;
                    end
                end
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end

        busy_next = (state_next == COLLECT);
    end

    assign bus.rx_data     = rx_data_reg;
    assign bus.reg_enable  = reg_enable_reg;
    assign bus.byte_count  = count_reg;
    assign bus.busy        = busy_reg;
    assign bus.frame_error = frame_error_reg;
endmodule

// File: tb/tb_rx_byte_assembler.sv
// Directed bench for rx_byte_assembler: a per-cycle vector table plus
// hand-written sequences for back-to-back frames, clear in DONE and async reset.
module tb_rx_byte_assembler;
    logic clk;
    logic rst;

    rx_byte_assembler_if bus ();

    rx_byte_assembler #(.TIMEOUT_CYCLES(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         v;
        logic [7:0]   d;
        logic         c;
        logic         re;
        logic [4:0]   cnt;
        logic         busy;
        logic         fe;
        logic [127:0] rx;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    localparam logic [127:0] W1   = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] W2   = 128'h101112131415161718191A1B1C1D1E1F;
    localparam logic [127:0] W3   = 128'hB0B1B2B3B4B5B6B7B8B9BABBBCBDBEBF;
    localparam logic [127:0] ONES = {128{1'b1}};
    localparam logic [127:0] W4   = 128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF;
    localparam logic [127:0] WAA  = {16{8'hAA}};
    localparam logic [127:0] W55  = {16{8'h55}};
    localparam logic [127:0] W5   = 128'h404142434445464748494A4B4C4D4E4F;

    task automatic add(input logic v, input logic [7:0] d, input logic c, input logic re,
                       input logic [4:0] cnt, input logic busy, input logic fe,
                       input logic [127:0] rx);
        vec_t t;
        t.v = v; t.d = d; t.c = c; t.re = re; t.cnt = cnt; t.busy = busy; t.fe = fe; t.rx = rx;
        tbl.push_back(t);
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic c);
        @(negedge clk);
        bus.byte_valid = v;
        bus.byte_data  = d;
        bus.clear      = c;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic re, input logic [4:0] cnt,
                           input logic busy, input logic fe, input logic [127:0] rx);
        chk({tag, " reg_enable"},  128'(bus.reg_enable),  128'(re));
        chk({tag, " byte_count"},  128'(bus.byte_count),  128'(cnt));
        chk({tag, " busy"},        128'(bus.busy),        128'(busy));
        chk({tag, " frame_error"}, 128'(bus.frame_error), 128'(fe));
        chk({tag, " rx_data"},     bus.rx_data,           rx);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;

        // Full frame 0x00..0x0F, then DONE -> IDLE
        for (int i = 0; i < 16; i++)
            add(1, 8'(i), 0, i == 15, (i == 15) ? 5'd0 : 5'(i + 1), i < 15, 0, (i == 15) ? W1 : '0);
        add(0, 8'h00, 0, 0, 5'd0, 0, 0, W1);
        // 5 bytes then 8 idle cycles: timeout on the 8th, then a clean frame
        for (int k = 0; k < 5; k++) add(1, 8'(8'hA0 + k), 0, 0, 5'(k + 1), 1, 0, W1);
        for (int k = 0; k < 7; k++) add(0, 8'h00, 0, 0, 5'd5, 1, 0, W1);
        add(0, 8'h00, 0, 0, 5'd0, 0, 1, W1);
        add(0, 8'h00, 0, 0, 5'd0, 0, 0, W1);
        for (int k = 0; k < 16; k++)
            add(1, 8'(8'h10 + k), 0, k == 15, (k == 15) ? 5'd0 : 5'(k + 1), k < 15, 0, (k == 15) ? W2 : W1);
        add(0, 8'h00, 0, 0, 5'd0, 0, 0, W2);
        // Byte arriving on what would be the 8th idle cycle is accepted
        for (int k = 0; k < 5; k++) add(1, 8'(8'hB0 + k), 0, 0, 5'(k + 1), 1, 0, W2);
        for (int k = 0; k < 7; k++) add(0, 8'h00, 0, 0, 5'd5, 1, 0, W2);
        for (int k = 5; k < 16; k++)
            add(1, 8'(8'hB0 + k), 0, k == 15, (k == 15) ? 5'd0 : 5'(k + 1), k < 15, 0, (k == 15) ? W3 : W2);
        add(0, 8'h00, 0, 0, 5'd0, 0, 0, W3);
        // clear together with byte_valid drops the byte
        for (int k = 0; k < 10; k++) add(1, 8'(8'h30 + k), 0, 0, 5'(k + 1), 1, 0, W3);
        add(1, 8'h99, 1, 0, 5'd0, 0, 0, W3);
        for (int k = 0; k < 16; k++)
            add(1, 8'hFF, 0, k == 15, (k == 15) ? 5'd0 : 5'(k + 1), k < 15, 0, (k == 15) ? ONES : W3);
        add(0, 8'h00, 0, 0, 5'd0, 0, 0, ONES);
        // Bytes spaced by 7 idle cycles never time out
        for (int k = 0; k < 16; k++) begin
            add(1, 8'(8'hC0 + k), 0, k == 15, (k == 15) ? 5'd0 : 5'(k + 1), k < 15, 0, (k == 15) ? W4 : ONES);
            if (k < 15)
                for (int j = 0; j < 7; j++) add(0, 8'h00, 0, 0, 5'(k + 1), 1, 0, ONES);
        end
        add(0, 8'h00, 0, 0, 5'd0, 0, 0, W4);

        // Reset state
        rst = 1'b1;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        bus.clear      = 1'b0;
        @(posedge clk);
        #1;
        chk_all("reset", 0, 5'd0, 0, 0, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].c);
            chk_all($sformatf("vec%0d", i), tbl[i].re, tbl[i].cnt, tbl[i].busy, tbl[i].fe, tbl[i].rx);
            $display("vec%0d v=%0b d=%h c=%0b -> re=%0b cnt=%0d busy=%0b fe=%0b", i, tbl[i].v,
                     tbl[i].d, tbl[i].c, bus.reg_enable, bus.byte_count, bus.busy, bus.frame_error);
        end

        // Back-to-back frames with the next frame's first byte in DONE
        pulses = 0;
        for (int k = 0; k < 16; k++) begin
            step(1, 8'hAA, 0);
            pulses += int'(bus.reg_enable);
        end
        chk_all("frameA end", 1, 5'd0, 0, 0, WAA);
        $display("frameA done rx=%h", bus.rx_data);
        step(1, 8'h55, 0);
        pulses += int'(bus.reg_enable);
        chk_all("frameB byte0 in DONE", 0, 5'd1, 1, 0, WAA);
        for (int k = 1; k < 16; k++) begin
            step(1, 8'h55, 0);
            pulses += int'(bus.reg_enable);
        end
        chk_all("frameB end", 1, 5'd0, 0, 0, W55);
        chk("b2b pulse count", 128'(pulses), 128'(2));
        $display("frameB done rx=%h pulses=%0d", bus.rx_data, pulses);

        // clear in DONE: no re-issued pulse, word held
        step(0, 8'h00, 1);
        chk_all("clear in DONE", 0, 5'd0, 0, 0, W55);
        $display("clear in DONE re=%0b cnt=%0d", bus.reg_enable, bus.byte_count);

        // Asynchronous reset mid-frame
        for (int k = 0; k < 7; k++) step(1, 8'(8'h60 + k), 0);
        chk_all("pre-reset partial", 0, 5'd7, 1, 0, W55);
        bus.byte_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk_all("async reset", 0, 5'd0, 0, 0, '0);
        $display("async reset rx=%h cnt=%0d", bus.rx_data, bus.byte_count);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1, 8'h40, 0);
        chk_all("first byte after reset", 0, 5'd1, 1, 0, '0);
        for (int k = 1; k < 16; k++) step(1, 8'(8'h40 + k), 0);
        chk_all("frame after reset", 1, 5'd0, 0, 0, W5);
        $display("post-reset frame rx=%h", bus.rx_data);
        step(0, 8'h00, 0);
        chk_all("idle after reset frame", 0, 5'd0, 0, 0, W5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
